// File: rtl/traffic_pkg.sv
// Shared constants for the pedestrian-crossing controller: FSM state
// encodings and default phase durations.
package traffic_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] GREEN  = 3'd0;
   localparam logic [STATE_W-1:0] YELLOW = 3'd1;
   localparam logic [STATE_W-1:0] RED    = 3'd2;
   localparam logic [STATE_W-1:0] ALLRED = 3'd3;
   localparam logic [STATE_W-1:0] FLASH  = 3'd4;

   localparam int unsigned DEF_CLK_DIV  = 12_000_000;
   localparam int unsigned DEF_GREEN_T  = 60;
   localparam int unsigned DEF_YELLOW_T = 5;
   localparam int unsigned DEF_RED_T    = 30;
   localparam int unsigned DEF_ALLRED_T = 2;
   localparam int unsigned DEF_CNT_W    = 8;

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every CLK_DIV cycles.
// Ports: clk, rst (async active-low), tick (registered, high while the
// count equals CLK_DIV-1).
module tick_gen #(
   parameter int unsigned CLK_DIV = 12_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] cnt;

   // tick is registered one count early so it coincides with count CLK_DIV-1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= (cnt == DIV_W'(CLK_DIV - 1)) ? '0 : cnt + DIV_W'(1);
         tick <= (cnt == DIV_W'(CLK_DIV - 2));
      end
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: pedestrian-crossing controller with latched request,
// minimum green, all-red clearance and optional night flashing.
// Build option: TRAFFIC_NIGHT_EN adds the night input and the FLASH state.
// Ports:
//   clk, rst (async active-low)
//   req         pedestrian button (async, synchronised here)
//   night       night-mode request (async, TRAFFIC_NIGHT_EN only)
//   tick        prescaler pulse
//   car_red/car_yellow/car_green, ped_walk   registered lamps
//   req_pending latched request not yet served
//   state       current FSM state
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
   parameter int unsigned GREEN_T  = DEF_GREEN_T,
   parameter int unsigned YELLOW_T = DEF_YELLOW_T,
   parameter int unsigned RED_T    = DEF_RED_T,
   parameter int unsigned ALLRED_T = DEF_ALLRED_T,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
`ifdef TRAFFIC_NIGHT_EN
   input  logic               night,
`endif
   output logic               tick,
   output logic               car_red,
   output logic               car_yellow,
   output logic               car_green,
   output logic               ped_walk,
   output logic               req_pending,
   output logic [STATE_W-1:0] state
);

   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

   logic               req_s1, req_s2, req_d;
   logic               req_edge;
   logic               night_on;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [STATE_W-1:0] state_nx;
   logic               red_nx, yel_nx, grn_nx, walk_nx, pend_nx;

   tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // request synchroniser plus edge register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_s1 <= 1'b0;
         req_s2 <= 1'b0;
         req_d  <= 1'b0;
      end else begin
         req_s1 <= req;
         req_s2 <= req_s1;
         req_d  <= req_s2;
      end
   end

   assign req_edge = req_s2 & ~req_d;

`ifdef TRAFFIC_NIGHT_EN
   logic night_s1, night_s2;

   // night-mode synchroniser
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         night_s1 <= 1'b0;
         night_s2 <= 1'b0;
      end else begin
         night_s1 <= night;
         night_s2 <= night_s1;
      end
   end

   assign night_on = night_s2;
`else
   assign night_on = 1'b0;
`endif

   // next state, phase counter, request latch and lamp decode
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pend_nx  = req_pending;
      red_nx   = 1'b0;
      yel_nx   = 1'b0;
      grn_nx   = 1'b0;
      walk_nx  = 1'b0;

      if (tick) begin
         if (night_on) begin
            state_nx = FLASH;
         end else begin
            case (state)
               GREEN:   if (cnt >= GREEN_LAST && req_pending) state_nx = YELLOW;
               YELLOW:  if (cnt == YELLOW_LAST) state_nx = RED;
               RED:     if (cnt == RED_LAST)    state_nx = ALLRED;
               ALLRED:  if (cnt == ALLRED_LAST) state_nx = GREEN;
               default: state_nx = ALLRED;   // leaving FLASH
            endcase
         end
      end

      // counter saturates in GREEN so an unserved green can last forever
      if (state_nx != state) begin
         cnt_nx = '0;
      end else if (tick && !(state == GREEN && cnt >= GREEN_LAST)) begin
         cnt_nx = cnt + CNT_W'(1);
      end

      // clearing on RED entry takes priority over a same-cycle request
      if ((state_nx == RED && state != RED) || state_nx == FLASH) begin
         pend_nx = 1'b0;
      end else if (req_edge && state != RED && state != FLASH) begin
         pend_nx = 1'b1;
      end

      case (state_nx)
         GREEN:   grn_nx = 1'b1;
         YELLOW:  yel_nx = 1'b1;
         RED: begin
            red_nx  = 1'b1;
            walk_nx = 1'b1;
         end
         ALLRED:  red_nx = 1'b1;
         // FLASH: yellow starts on, then toggles each tick
         default: yel_nx = (state != FLASH) ? 1'b1 : (car_yellow ^ tick);
      endcase
   end

   // FSM state, counter and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= GREEN;
         cnt         <= '0;
         req_pending <= 1'b0;
         car_red     <= 1'b0;
         car_yellow  <= 1'b0;
         car_green   <= 1'b1;
         ped_walk    <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         req_pending <= pend_nx;
         car_red     <= red_nx;
         car_yellow  <= yel_nx;
         car_green   <= grn_nx;
         ped_walk    <= walk_nx;
      end
   end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised pedestrian-crossing traffic-light controller with a built-in one-second tick prescaler, latched pedestrian request, minimum-green enforcement and an all-red clearance phase. It sits between the board clock/button inputs and the car/pedestrian lamp drivers, and replaces the fixed-timing semaphore counter. All phase durations are in ticks and are set per instance.

## Interface
- CLK_DIV, 12_000_000: clock cycles per tick; must be ≥ 2.
- GREEN_T, 60: minimum car-green duration in ticks; must be ≥ 1.
- YELLOW_T, 5: car-yellow duration in ticks; must be ≥ 1.
- RED_T, 30: car-red / pedestrian-walk duration in ticks; must be ≥ 1.
- ALLRED_T, 2: clearance duration in ticks (car red, walk off); must be ≥ 1.
- CNT_W, 8: phase counter width; must hold max(duration) − 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- req  in  1  pedestrian button, asynchronous, level or pulse.
- night  in  1  night-mode request, asynchronous (present only with TRAFFIC_NIGHT_EN).
- tick  out  1  one-cycle pulse every CLK_DIV cycles.
- car_red, car_yellow, car_green  out  1 each  car lamps, registered.
- ped_walk  out  1  pedestrian walk lamp, registered.
- req_pending  out  1  latched request not yet served.
- state  out  3  current FSM state encoding.

## Operation
- Reset values: tick=0, car_green=1, car_red=0, car_yellow=0, ped_walk=0, req_pending=0, state=GREEN, prescaler=0, phase counter=0.
- req and night pass through 2-FF synchronisers. req is rising-edge detected after synchronisation.
- Prescaler counts 0..CLK_DIV−1 and wraps. tick=1 in the cycle when the count equals CLK_DIV−1.
- FSM states: GREEN(0), YELLOW(1), RED(2), ALLRED(3), FLASH(4, macro only). The phase counter clears on every state entry and increments on each tick while the FSM stays in the state.
- GREEN: on a tick with counter ≥ GREEN_T−1 and req_pending=1 → YELLOW. Without a pending request, the FSM stays in GREEN indefinitely and the counter saturates at GREEN_T−1.
- YELLOW: on a tick with counter = YELLOW_T−1 → RED.
- RED: car_red=1, ped_walk=1. On a tick with counter = RED_T−1 → ALLRED.
- ALLRED: car_red=1, ped_walk=0. On a tick with counter = ALLRED_T−1 → GREEN.
- req_pending is set by a synchronised req edge in GREEN, YELLOW or ALLRED. It is cleared on entry to RED. If a request edge and the RED entry occur in the same cycle, the clear wins. Request edges during RED are ignored.
- Lamp outputs are decoded from the next state and registered, so lamps and state change on the same edge.
- Exactly one car lamp is on in every non-FLASH state.

## Timing
- State and lamp transitions occur on the clock edge that samples tick=1; all of them are tick-aligned.
- req_pending rises 3 cycles after a req rising edge (2 sync stages + edge register).
- Phase lengths measured between transition edges: YELLOW = YELLOW_T·CLK_DIV cycles, RED = RED_T·CLK_DIV cycles, ALLRED = ALLRED_T·CLK_DIV cycles. GREEN lasts ≥ GREEN_T·CLK_DIV cycles.
- Asserting rst at any point forces the reset values immediately, asynchronously. The first tick after release occurs CLK_DIV cycles later.

## Configuration
- TRAFFIC_NIGHT_EN defined: the night port and the FLASH state exist.
  - Synchronised night=1 → the FSM enters FLASH at the next tick, from any state.
  - In FLASH, car_yellow toggles each tick (starting at 1) and all other lamps are 0. req_pending is held at 0 and requests are ignored.
  - night=0 → ALLRED at the next tick, then normal operation.
- TRAFFIC_NIGHT_EN undefined: no night port, FLASH encoding is unused, and state never equals 4.

## Structure
- Package traffic_pkg: state encoding constants (GREEN, YELLOW, RED, ALLRED, FLASH) and default duration constants.
- Sub-module tick_gen: prescaler parametrised by CLK_DIV, with output tick.
- Synchroniser, edge detector and FSM stay in traffic_light_ctrl.

## Test plan
Use CLK_DIV=4, GREEN_T=3, YELLOW_T=2, RED_T=3, ALLRED_T=1, CNT_W=4 unless noted.
- Reset, then idle 40 cycles → car_green=1 throughout, tick pulses every 4th cycle, state=0.
- req pulse at cycle 2 → req_pending=1 at cycle 5; GREEN ends at the 3rd tick; YELLOW lasts 8 cycles, RED/walk 12, ALLRED 4, then GREEN with req_pending=0.
- req at cycle 30, after minimum green → YELLOW at the first tick after req_pending rises.
- req during RED → no latch; after ALLRED, GREEN persists past 3 ticks. A second req during ALLRED is latched and YELLOW follows 3 ticks into GREEN.
- rst asserted mid-YELLOW → same cycle: car_green=1, car_yellow=0, req_pending=0, state=0.
- TRAFFIC_NIGHT_EN: night=1 in RED → FLASH at the next tick, car_yellow toggles 1,0,1 per tick, req ignored. night=0 → ALLRED for 1 tick, then GREEN.
